pr_bridge_arb: RTL

Two-master arbiter and bridge for the peripheral bus that carries the two timers (Timer1 window 0x0000_7f00–0x0000_7f0b, Timer2 window 0x0000_7f10–0x0000_7f1b). It shares that bus between master 0 (the CPU M stage) and master 1 (an auxiliary DMA/debug master). It sequences each access through a small FSM, decodes the target device, and blocks illegal accesses. It returns registered read data with a one-cycle ack pulse, and gives the CPU a stall signal while its access is outstanding.

---
 rtl/pr_bridge_arb.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pr_bridge_arb.sv
// Two-master round-robin arbiter and bridge onto the timer peripheral bus.
// Each access takes IDLE -> ACCESS -> RESP; illegal addresses and COUNT writes are rejected.
module pr_bridge_arb #(
  parameter logic [31:0] TIMER1_BASE = 32'h0000_7f00,
  parameter logic [31:0] TIMER2_BASE = 32'h0000_7f10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:2] m0_addr,
  input  logic [31:0] m0_wd,
  output logic        m0_ack,
  output logic [31:0] m0_rd,
  output logic        m0_err,
  output logic        m0_stall,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:2] m1_addr,
  input  logic [31:0] m1_wd,
  output logic        m1_ack,
  output logic [31:0] m1_rd,
  output logic        m1_err,
  output logic [3:2]  dev_addr,
  output logic [31:0] dev_wd,
  output logic        dev0_we,
  output logic        dev1_we,
  input  logic [31:0] dev0_rd,
  input  logic [31:0] dev1_rd,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_r;
  logic        last_r;
  logic        cur_r;
  logic        we_r;
  logic        sel0_r;
  logic        sel1_r;
  logic        err_r;

  logic        gnt_s;
  logic        w_we_s;
  logic [31:2] w_addr_s;
  logic [31:0] w_wd_s;
  logic        w_sel0_s;
  logic        w_sel1_s;
  logic        w_err_s;
  logic [31:0] rd_sel_s;

  // Each window holds three words: base, base+4, base+8.
  function automatic logic in_window(input logic [31:2] a, input logic [31:0] base);
    logic [31:0] byte_a;
    byte_a = {a, 2'b00};
    return (byte_a >= base) && (byte_a <= (base + 32'd8));
  endfunction

  // Stall covers the request cycles up to, but not including, the ack cycle.
  assign m0_stall = m0_req & ~m0_ack;

  // Winner selection and decode of the winning request.
  always_comb begin
    gnt_s = 1'b0;
    if (m0_req && m1_req) begin
      gnt_s = ~last_r;
    end else if (m1_req) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
    w_we_s   = gnt_s ? m1_we   : m0_we;
    w_addr_s = gnt_s ? m1_addr : m0_addr;
    w_wd_s   = gnt_s ? m1_wd   : m0_wd;
    w_sel0_s = in_window(w_addr_s, TIMER1_BASE);
    w_sel1_s = in_window(w_addr_s, TIMER2_BASE);
    w_err_s  = ~(w_sel0_s | w_sel1_s) | (w_we_s & (w_addr_s[3:2] == 2'd2));
  end

  // Read data captured in ACCESS: device data for a legal read, zero otherwise.
  always_comb begin
    rd_sel_s = 32'd0;
    if (!we_r && !err_r) begin
      if (sel0_r) begin
        rd_sel_s = dev0_rd;
      end else if (sel1_r) begin
        rd_sel_s = dev1_rd;
      end else begin
        rd_sel_s = 32'd0;
      end
    end else begin
      rd_sel_s = 32'd0;
    end
  end

  // Access sequencer with registered device and master outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      last_r   <= 1'b1;
      cur_r    <= 1'b0;
      we_r     <= 1'b0;
      sel0_r   <= 1'b0;
      sel1_r   <= 1'b0;
      err_r    <= 1'b0;
      dev_addr <= 2'd0;
      dev_wd   <= 32'd0;
      dev0_we  <= 1'b0;
      dev1_we  <= 1'b0;
      busy     <= 1'b0;
      m0_ack   <= 1'b0;
      m0_rd    <= 32'd0;
      m0_err   <= 1'b0;
      m1_ack   <= 1'b0;
      m1_rd    <= 32'd0;
      m1_err   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (m0_req || m1_req) begin
            last_r   <= gnt_s;
            cur_r    <= gnt_s;
            we_r     <= w_we_s;
            sel0_r   <= w_sel0_s;
            sel1_r   <= w_sel1_s;
            err_r    <= w_err_s;
            dev_addr <= w_addr_s[3:2];
            dev_wd   <= w_wd_s;
            // Strobe is registered here so it is high exactly during ACCESS.
            dev0_we  <= w_we_s & w_sel0_s & ~w_err_s;
            dev1_we  <= w_we_s & w_sel1_s & ~w_err_s;
            busy     <= 1'b1;
            state_r  <= ACCESS;
          end else begin
            state_r  <= IDLE;
          end
        end
        ACCESS: begin
          dev0_we <= 1'b0;
          dev1_we <= 1'b0;
          if (cur_r) begin
            m1_ack <= 1'b1;
            m1_rd  <= rd_sel_s;
            m1_err <= err_r;
          end else begin
            m0_ack <= 1'b1;
            m0_rd  <= rd_sel_s;
            m0_err <= err_r;
          end
          state_r <= RESP;
        end
        RESP: begin
          m0_ack  <= 1'b0;
          m0_rd   <= 32'd0;
          m0_err  <= 1'b0;
          m1_ack  <= 1'b0;
          m1_rd   <= 32'd0;
          m1_err  <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          dev0_we <= 1'b0;
          dev1_we <= 1'b0;
          m0_ack  <= 1'b0;
          m0_rd   <= 32'd0;
          m0_err  <= 1'b0;
          m1_ack  <= 1'b0;
          m1_rd   <= 32'd0;
          m1_err  <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
